mmio_port_unit: RTL
===================

Name: mmio_port_unit

Overview:
- Memory-mapped I/O stage directly downstream of the single-cycle MIPS datapath.
- Consumes the ALU result as an address and register-file read data 2 as store data, and replaces the tied-off PortOut with a buffered, handshaked output port.
- Synchronizes the 8-bit PortIn for lw reads and exposes a status word.
- ReadData is combinational, so lw completes in the same cycle.

Parameters:
OUT_ADDR  32'h1001_0024  word address of output port (sw writes, lw reads back current PortOut)
IN_ADDR   32'h1001_0028  word address of synchronized input port (lw only)
STAT_ADDR 32'h1001_002C  word address of status register (lw only)

Ports:
clk            input   1   rising-edge clock
reset          input   1   asynchronous, active-low reset
Address        input   32  ALU result (effective address)
WriteData      input   32  store data (rt contents)
MemWrite       input   1   sw in current cycle
MemRead        input   1   lw in current cycle
PortIn         input   8   asynchronous external input
PortAck        input   1   external consumer accepted PortOut this cycle
IOSelect       output  1   Address equals OUT_ADDR, IN_ADDR or STAT_ADDR (combinational)
ReadData       output  32  lw result for I/O addresses (combinational)
PortOut        output  32  output port data
PortOutValid   output  1   PortOut holds unaccepted data

Behaviour:
- Reset (reset=0, asynchronous): all state clears.
  - PortOut=0, PortOutValid=0, pending buffer empty with data 0.
  - Sync flops=0, previous-sample register=0.
  - InChanged=0, Overrun=0.
- Address decode:
  - Exact 32-bit compare against the parameter addresses.
  - Any other address: IOSelect=0 and ReadData=0; writes and reads have no effect.
- Input path:
  - Two-flop synchronizer (s1, s2), plus a previous-sample register prev<=s2.
  - The PortIn value is visible on an IN_ADDR read after 2 rising edges.
  - InChanged (sticky) is set on the edge where s2!=prev, i.e. on the 3rd edge after the PortIn change.
- ReadData (valid only when MemRead=1; otherwise 0):
  - OUT_ADDR: returns PortOut.
  - IN_ADDR: returns {24'b0,s2}.
  - STAT_ADDR: returns {28'b0, Overrun, PendingFull, PortOutValid, InChanged} in bits [3:0].
- Read side effects, applied at the clock edge of the lw cycle:
  - An IN_ADDR read clears InChanged.
  - A STAT_ADDR read clears Overrun.
  - If a set condition occurs in the same cycle as the clearing read, the set wins and the flag stays 1.
- Output path: PortOut register plus a 1-deep pending buffer. With W = MemWrite & Address==OUT_ADDR, evaluated per edge:
  - EMPTY (valid=0), W: PortOut<=WriteData, valid<=1. PortAck is ignored while valid=0.
  - BUSY (valid=1, no pending):
    - Ack & W: PortOut<=WriteData, valid stays 1.
    - Ack only: valid<=0.
    - W only: pending<=WriteData, PendingFull<=1.
  - FULL (valid=1, pending):
    - Ack & W: PortOut<=pending, pending<=WriteData, stays FULL.
    - Ack only: PortOut<=pending, PendingFull<=0.
    - W only: write dropped, Overrun<=1, PortOut and pending unchanged.
- PortOut is never modified while valid=1 and PortAck=0, except by reset.
- MemRead and MemWrite both asserted: both actions are performed. The read returns the pre-edge value.
- Reset mid-transfer discards PortOut, pending data and all flags immediately. No ack is required afterwards.
- Latency: a sw is visible on PortOut/PortOutValid one edge after the store cycle, when the unit is EMPTY or acked in that cycle.

Test Plan:
- Reset: hold reset=0 with random inputs -> PortOut=0, PortOutValid=0, status lw returns 0. Release reset -> values stay 0 until stimulus.
- Single store: sw 0xDEADBEEF to 0x10010024 with PortAck=0 -> next edge PortOut=0xDEADBEEF, valid=1, held for 10 cycles. PortAck=1 for one cycle -> valid=0.
- Buffering/overrun: sw 0x11, 0x22, 0x33 on consecutive cycles, no ack -> PortOut=0x11, status=0x6 then 0xE (0x33 dropped). Ack -> PortOut=0x22. lw STAT_ADDR -> returns 0xA, and the following status read returns 0x2.
- Simultaneous ack and write in FULL: PortOut=0x22, pending=0x33, ack & sw 0x44 -> PortOut=0x33, pending=0x44, Overrun stays 0.
- Input sync: PortIn 0x00->0xA5 -> lw IN_ADDR returns 0xA5 from the 2nd edge, InChanged=1 after the 3rd edge. lw IN_ADDR clears it. A change coinciding with the clearing read leaves InChanged=1.
- Decode: lw/sw at 0x10010020 and 0x10010025 -> IOSelect=0, ReadData=0, no state change. Reset asserted while FULL -> all outputs 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_port_unit.sv
// mmio_port_unit
//   Memory-mapped I/O stage that sits after the single-cycle MIPS datapath.
//   Decodes three word addresses and provides three I/O paths:
//     - A buffered output port: the PortOut register plus a 1-deep pending
//       buffer, with a valid/ack handshake toward the external consumer.
//     - A synchronized 8-bit input port with a sticky "input changed" flag.
//     - A status word: {Overrun, PendingFull, PortOutValid, InChanged}.
//   ReadData is combinational, so a lw completes in its own cycle.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   Address       effective address (ALU result)
//   WriteData     store data (rt contents)
//   MemWrite      sw in the current cycle
//   MemRead       lw in the current cycle
//   PortIn        asynchronous external 8-bit input
//   PortAck       external consumer accepted PortOut this cycle
//   IOSelect      Address hits one of the three I/O words (combinational)
//   ReadData      lw result for I/O addresses, 0 otherwise (combinational)
//   PortOut       output port data
//   PortOutValid  PortOut holds data that has not been accepted yet
module mmio_port_unit #(
  parameter logic [31:0] OUT_ADDR  = 32'h1001_0024,
  parameter logic [31:0] IN_ADDR   = 32'h1001_0028,
  parameter logic [31:0] STAT_ADDR = 32'h1001_002C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  input  logic        PortAck,
  output logic        IOSelect,
  output logic [31:0] ReadData,
  output logic [31:0] PortOut,
  output logic        PortOutValid
);

  logic [31:0] pend_data;
  logic        pend_full;
  logic [7:0]  s1;
  logic [7:0]  s2;
  logic [7:0]  prev;
  logic        in_changed;
  logic        overrun;

  logic hit_out;
  logic hit_in;
  logic hit_stat;
  logic wr_out;
  logic rd_in;
  logic rd_stat;
  logic overrun_set;
  logic change_set;

  assign hit_out  = (Address == OUT_ADDR);
  assign hit_in   = (Address == IN_ADDR);
  assign hit_stat = (Address == STAT_ADDR);
  assign IOSelect = hit_out | hit_in | hit_stat;

  assign wr_out  = MemWrite & hit_out;
  assign rd_in   = MemRead & hit_in;
  assign rd_stat = MemRead & hit_stat;

  // A store arriving while both PortOut and the pending slot hold
  // unaccepted data (and no ack frees a slot) has nowhere to go.
  assign overrun_set = wr_out & PortOutValid & pend_full & ~PortAck;
  assign change_set  = (s2 != prev);

  always_comb begin
    ReadData = 32'h0;
    if (MemRead) begin
      if (hit_out) begin
        ReadData = PortOut;
      end else if (hit_in) begin
        ReadData = {24'h0, s2};
      end else if (hit_stat) begin
        ReadData = {28'h0, overrun, pend_full, PortOutValid, in_changed};
      end
    end
  end

  // Output port: PortOut + 1-deep pending buffer. PortOut only moves when it
  // is empty or the consumer acks it, so the consumer always sees stable data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PortOut      <= 32'h0;
      PortOutValid <= 1'b0;
      pend_data    <= 32'h0;
      pend_full    <= 1'b0;
    end else if (!PortOutValid) begin
      // Ack is meaningless with nothing on the port.
      if (wr_out) begin
        PortOut      <= WriteData;
        PortOutValid <= 1'b1;
      end
    end else if (!pend_full) begin
      if (PortAck && wr_out) begin
        PortOut <= WriteData;
      end else if (PortAck) begin
        PortOutValid <= 1'b0;
      end else if (wr_out) begin
        pend_data <= WriteData;
        pend_full <= 1'b1;
      end
    end else if (PortAck) begin
      // Pending data advances; a simultaneous store refills the slot.
      PortOut <= pend_data;
      if (wr_out) begin
        pend_data <= WriteData;
      end else begin
        pend_full <= 1'b0;
      end
    end
  end

  // Input port: two-flop synchronizer plus a previous-sample register that
  // feeds the change detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 8'h0;
      s2   <= 8'h0;
      prev <= 8'h0;
    end else begin
      s1   <= PortIn;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Sticky flags, cleared by reading their register; a set in the same
  // cycle as the clearing read takes priority so no event is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_changed <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      in_changed <= change_set | (in_changed & ~rd_in);
      overrun    <= overrun_set | (overrun & ~rd_stat);
    end
  end

endmodule
